// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back queue.
package wb_pkg;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_SLOTS = 4;
  localparam int WB_PORTS = 2;

  // Input slot order is program order
  localparam int SLOT_ALU0 = 0;
  localparam int SLOT_ALU1 = 1;
  localparam int SLOT_MEM1 = 2;
  localparam int SLOT_MEM2 = 3;

  // addr == 0 means "no write"
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_compact.sv
// Combinational 4-to-4 lane packer: squeezes out empty slots while keeping
// slot (program) order, and reports how many valid entries there are.
module wb_compact
  import wb_pkg::*;
(
  input  wb_entry_t [WB_SLOTS-1:0] slot,
  output logic      [2:0]          k,
  output wb_entry_t [WB_SLOTS-1:0] lane
);

  // Each valid slot lands at the lane equal to the number of valid slots before it
  always_comb begin
    k    = '0;
    lane = '0;
    for (int i = 0; i < WB_SLOTS; i++) begin
      if (slot[i].addr != '0) begin
        lane[k[1:0]] = slot[i];
        k            = k + 3'd1;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: gathers up to four results per cycle into a FIFO and
// drains up to two per cycle onto the register-file write ports in order,
// never driving the same register on both ports in one cycle.
// The entry layout comes from wb_pkg, so AW/DW must match WB_AW/WB_DW.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] in0_addr,
  input  logic [DW-1:0] in0_data,
  input  logic [AW-1:0] in1_addr,
  input  logic [DW-1:0] in1_data,
  input  logic [AW-1:0] in2_addr,
  input  logic [DW-1:0] in2_data,
  input  logic [AW-1:0] in3_addr,
  input  logic [DW-1:0] in3_data,
  output logic [AW-1:0] wr0_addr,
  output logic [DW-1:0] wr0_data,
  output logic [AW-1:0] wr1_addr,
  output logic [DW-1:0] wr1_data,
  output logic          stall,
  output logic [31:0]   busy_mask,
  output logic          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [WB_SLOTS-1:0] slot;
  wb_entry_t [WB_SLOTS-1:0] lane;
  logic      [2:0]          k;

  wb_entry_t         mem   [DEPTH];
  wb_entry_t         mem_n [DEPTH];
  logic [PW-1:0]     head, tail, head1, head_n, tail_n;
  logic [CW-1:0]     count, count_n, free, k_acc;
  logic [1:0]        n_deq;
  logic              acc;
  wb_entry_t         wr0_n, wr1_n;
  logic [31:0]       busy_n;
  logic              stall_n;

  assign slot[SLOT_ALU0] = '{addr: in0_addr, data: in0_data};
  assign slot[SLOT_ALU1] = '{addr: in1_addr, data: in1_data};
  assign slot[SLOT_MEM1] = '{addr: in2_addr, data: in2_data};
  assign slot[SLOT_MEM2] = '{addr: in3_addr, data: in3_data};

  wb_compact u_compact (
    .slot (slot),
    .k    (k),
    .lane (lane)
  );

  // Dequeue and enqueue both judged on pre-edge state; next queue image feeds busy_mask
  always_comb begin
    head1 = head + PW'(1);
    n_deq = 2'd0;
    wr0_n = '0;
    wr1_n = '0;
    if (count >= CW'(1)) begin
      n_deq = 2'd1;
      wr0_n = mem[head];
      // Same-register pair: hold the younger one back for a cycle
      if (count >= CW'(2) && mem[head1].addr != mem[head].addr) begin
        n_deq = 2'd2;
        wr1_n = mem[head1];
      end
    end

    // All-or-nothing acceptance; space freed by this edge's dequeue is not usable yet
    free    = CW'(DEPTH) - count;
    acc     = CW'(k) <= free;
    k_acc   = acc ? CW'(k) : '0;
    count_n = count - CW'(n_deq) + k_acc;
    head_n  = head + PW'(n_deq);
    tail_n  = tail + PW'(k_acc);

    for (int i = 0; i < DEPTH; i++) mem_n[i] = mem[i];
    for (int j = 0; j < WB_SLOTS; j++) begin
      if (acc && j < int'(k)) mem_n[tail + PW'(j)] = lane[j];
    end

    busy_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < int'(count_n)) busy_n = busy_n | (32'd1 << mem_n[head_n + PW'(i)].addr);
    end
    busy_n[0] = 1'b0;

    // Stall whenever a full four-wide set might not fit next cycle
    stall_n = (CW'(DEPTH) - count_n) < CW'(WB_SLOTS);
  end

  // Entry storage carries no reset: validity is tracked by head/count alone
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
  end

  // Pointers, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      wr0_addr  <= '0;
      wr0_data  <= '0;
      wr1_addr  <= '0;
      wr1_data  <= '0;
      stall     <= 1'b0;
      busy_mask <= '0;
      overflow  <= 1'b0;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      wr0_addr  <= wr0_n.addr;
      wr0_data  <= wr0_n.data;
      wr1_addr  <= wr1_n.addr;
      wr1_data  <= wr1_n.data;
      stall     <= stall_n;
      busy_mask <= busy_n;
      if (!acc) overflow <= 1'b1;
    end
  end

endmodule
